// File: rtl/uart_io_ctrl.sv
// uart_io_ctrl: memory-mapped UART/counter I/O block with RX FIFO and 1-cycle registered reads
module uart_io_ctrl #(
  parameter int         RX_DEPTH  = 4,
  parameter logic [3:0] IO_NIBBLE = 4'h8
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        stall,
  input  logic [31:0] addr,
  input  logic        re,
  input  logic [3:0]  we,
  input  logic [31:0] din,
  input  logic        inst_retire,
  output logic [31:0] dout,
  output logic        io_sel,
  output logic [7:0]  uart_din,
  output logic        uart_din_valid,
  input  logic        uart_din_ready,
  input  logic [7:0]  uart_dout,
  input  logic        uart_dout_valid,
  output logic        uart_dout_ready
);
  localparam int AW = $clog2(RX_DEPTH);
  logic [7:0]  mem_q [RX_DEPTH];
  logic [7:0]  mem_d [RX_DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [31:0] dout_q, dout_d, cyc_q, cyc_d, ins_q, ins_d;
  logic        io_sel_q, io_sel_d, txv_q, txv_d;
  logic [7:0]  txb_q, txb_d;
  logic        io, rd, wr, rx_avail, push, pop, tx_ok, clr;
  logic [7:0]  a;
  logic [31:0] rdata;
  logic        unused_bits;
  assign unused_bits     = ^{addr[27:8], din[31:8]};
  assign io              = addr[31:28] == IO_NIBBLE;
  assign a               = addr[7:0];
  assign rd              = re && !stall && io;
  assign wr              = |we && !stall && io;
  assign rx_avail        = cnt_q != '0;
  // the count only reaches RX_DEPTH (a power of 2) when full, so its MSB is the full flag
  assign uart_dout_ready = !cnt_q[AW] && !Reset;
  assign push            = uart_dout_valid && uart_dout_ready;
  assign pop             = rd && a == 8'h04 && rx_avail;
  assign tx_ok           = wr && a == 8'h08 && !txv_q;
  assign clr             = wr && a == 8'h18;
  assign dout            = dout_q;
  assign io_sel          = io_sel_q;
  assign uart_din        = txb_q;
  assign uart_din_valid  = txv_q;
  always_comb begin
    rdata = a == 8'h00 ? {30'b0, rx_avail, !txv_q} :
            a == 8'h04 ? {24'b0, rx_avail ? mem_q[rp_q] : 8'h00} :
            a == 8'h10 ? cyc_q :
            a == 8'h14 ? ins_q : 32'h0;
    mem_d = mem_q;
    if (push) mem_d[wp_q] = uart_dout;
    wp_d     = push ? wp_q + 1'b1 : wp_q;
    rp_d     = pop ? rp_q + 1'b1 : rp_q;
    cnt_d    = (push && !pop) ? cnt_q + 1'b1 : (pop && !push) ? cnt_q - 1'b1 : cnt_q;
    dout_d   = rd ? rdata : dout_q;
    io_sel_d = (re && !stall) ? io : io_sel_q;
    txv_d    = tx_ok ? 1'b1 : (txv_q && uart_din_ready) ? 1'b0 : txv_q;
    txb_d    = tx_ok ? din[7:0] : txb_q;
    cyc_d    = clr ? 32'h0 : cyc_q + 32'h1;
    ins_d    = clr ? 32'h0 : ins_q + {31'b0, inst_retire && !stall};
  end
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      mem_q    <= '{default: 8'h00};
      wp_q     <= '0;
      rp_q     <= '0;
      cnt_q    <= '0;
      dout_q   <= '0;
      io_sel_q <= 1'b0;
      txv_q    <= 1'b0;
      txb_q    <= '0;
      cyc_q    <= '0;
      ins_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      io_sel_q <= io_sel_d;
      txv_q    <= txv_d;
      txb_q    <= txb_d;
      cyc_q    <= cyc_d;
      ins_q    <= ins_d;
    end
  end
endmodule

// File: tb/tb_uart_io_ctrl.sv
// tb_uart_io_ctrl: directed and randomized checks of uart_io_ctrl against a queue-based model
module tb_uart_io_ctrl;
  localparam int DEPTH = 4;
  logic        Clock, Reset, stall, re, inst_retire;
  logic [31:0] addr, din, dout;
  logic [3:0]  we;
  logic        io_sel, uart_din_valid, uart_din_ready, uart_dout_valid, uart_dout_ready;
  logic [7:0]  uart_din, uart_dout;
  int n_vec = 0;
  int n_err = 0;
  logic [7:0]  m_fifo[$];
  logic        m_txv, m_iosel;
  logic [7:0]  m_txb;
  logic [31:0] m_cyc, m_ins, m_dout;

  uart_io_ctrl #(.RX_DEPTH(DEPTH), .IO_NIBBLE(4'h8)) dut (
    .Clock(Clock), .Reset(Reset), .stall(stall), .addr(addr), .re(re), .we(we), .din(din),
    .inst_retire(inst_retire), .dout(dout), .io_sel(io_sel), .uart_din(uart_din),
    .uart_din_valid(uart_din_valid), .uart_din_ready(uart_din_ready), .uart_dout(uart_dout),
    .uart_dout_valid(uart_dout_valid), .uart_dout_ready(uart_dout_ready));

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic model_clear();
    m_fifo = {};
    m_txv = 0; m_txb = 0; m_iosel = 0; m_cyc = 0; m_ins = 0; m_dout = 0;
  endtask

  task automatic bus(input logic r, input logic [3:0] w, input logic [31:0] ad, input logic [31:0] d);
    re = r; we = w; addr = ad; din = d;
  endtask

  // Evaluate the register-map rules on pre-edge state, advance one clock, then commit.
  task automatic tick();
    logic io, rd, wr, pushing, popping, clr, tx_take;
    logic [7:0] a, rx_byte;
    logic [31:0] rv;
    io = addr[31:28] == 4'h8;
    a = addr[7:0];
    rd = re && !stall && io;
    wr = (we != 0) && !stall && io;
    case (a)
      8'h00:   rv = {30'b0, m_fifo.size() != 0, !m_txv};
      8'h04:   rv = (m_fifo.size() != 0) ? {24'b0, m_fifo[0]} : 32'h0;
      8'h10:   rv = m_cyc;
      8'h14:   rv = m_ins;
      default: rv = 32'h0;
    endcase
    pushing = uart_dout_valid && m_fifo.size() < DEPTH;
    popping = rd && a == 8'h04 && m_fifo.size() != 0;
    clr = wr && a == 8'h18;
    tx_take = wr && a == 8'h08 && !m_txv;
    rx_byte = uart_dout;
    @(posedge Clock);
    #1;
    if (popping) void'(m_fifo.pop_front());
    if (pushing) m_fifo.push_back(rx_byte);
    if (m_txv && uart_din_ready) m_txv = 0;
    else if (tx_take) begin m_txv = 1; m_txb = din[7:0]; end
    if (clr) begin m_cyc = 0; m_ins = 0; end
    else begin m_cyc = m_cyc + 1; m_ins = m_ins + ((inst_retire && !stall) ? 1 : 0); end
    if (re && !stall) begin m_iosel = io; if (io) m_dout = rv; end
  endtask

  task automatic test_reset();
    Reset = 1; stall = 0; inst_retire = 0; uart_din_ready = 0; uart_dout_valid = 0; uart_dout = 0;
    bus(0, 0, 0, 0);
    model_clear();
    #3;
    n_vec++; if (uart_din_valid !== 1'b0 || uart_dout_ready !== 1'b0 || dout !== 32'h0 || io_sel !== 1'b0) begin n_err++;
      $display("FAIL reset_outputs valid=%b ready=%b dout=%h io_sel=%b exp 0/0/0/0", uart_din_valid, uart_dout_ready, dout, io_sel); end
    @(negedge Clock); Reset = 0; #1;
    n_vec++; if (uart_dout_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready got=%b exp=1", uart_dout_ready); end
    bus(0, 4'hF, 32'h8000_0008, 32'h55);
    tick();
    bus(0, 0, 0, 0);
    n_vec++; if (uart_din_valid !== 1'b1) begin n_err++; $display("FAIL reset_pre_tx valid=%b exp=1", uart_din_valid); end
    #2 Reset = 1;
    #1;
    n_vec++; if (uart_din_valid !== 1'b0 || uart_dout_ready !== 1'b0) begin n_err++;
      $display("FAIL reset_async valid=%b ready=%b exp 0/0", uart_din_valid, uart_dout_ready); end
    model_clear();
    @(negedge Clock); Reset = 0;
    bus(1, 0, 32'h8000_0000, 0);
    tick();
    bus(0, 0, 0, 0);
    n_vec++; if (dout !== 32'h1 || io_sel !== 1'b1) begin n_err++; $display("FAIL reset_status dout=%h io_sel=%b exp 00000001/1", dout, io_sel); end
  endtask

  task automatic test_tx();
    uart_din_ready = 0;
    bus(0, 4'h1, 32'h8000_0008, 32'hAB41);
    tick();
    bus(0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      n_vec++; if (uart_din !== 8'h41 || uart_din_valid !== 1'b1) begin n_err++;
        $display("FAIL tx_hold cyc%0d din=%h valid=%b exp 41/1", i, uart_din, uart_din_valid); end
      tick();
    end
    bus(0, 4'h1, 32'h8000_0008, 32'h42);
    tick();
    n_vec++; if (uart_din !== 8'h41) begin n_err++; $display("FAIL tx_drop din=%h exp=41", uart_din); end
    bus(1, 0, 32'h8000_0000, 0);
    tick();
    n_vec++; if (dout !== 32'h0) begin n_err++; $display("FAIL tx_busy_status dout=%h exp=00000000", dout); end
    bus(0, 0, 0, 0);
    uart_din_ready = 1;
    tick();
    uart_din_ready = 0;
    n_vec++; if (uart_din_valid !== 1'b0) begin n_err++; $display("FAIL tx_release valid=%b exp=0", uart_din_valid); end
    bus(1, 0, 32'h8000_0000, 0);
    tick();
    bus(0, 0, 0, 0);
    n_vec++; if (dout !== 32'h1) begin n_err++; $display("FAIL tx_idle_status dout=%h exp=00000001", dout); end
  endtask

  task automatic test_rx_fill();
    logic [7:0] exp_b [6] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h00};
    for (int i = 0; i < 4; i++) begin
      uart_dout_valid = 1; uart_dout = 8'h10 + 8'(i);
      tick();
    end
    n_vec++; if (uart_dout_ready !== 1'b0) begin n_err++; $display("FAIL rx_full_ready got=%b exp=0", uart_dout_ready); end
    uart_dout = 8'h14;
    bus(1, 0, 32'h8000_0000, 0);
    tick();
    n_vec++; if (dout !== 32'h3 || uart_dout_ready !== 1'b0) begin n_err++;
      $display("FAIL rx_full_status dout=%h ready=%b exp 00000003/0", dout, uart_dout_ready); end
    for (int i = 0; i < 6; i++) begin
      bus(1, 0, 32'h8000_0004, 0);
      tick();
      if (i == 1) uart_dout_valid = 0;
      n_vec++; if (dout !== {24'b0, exp_b[i]} || dout !== m_dout) begin n_err++;
        $display("FAIL rx_read%0d dout=%h exp=%h", i, dout, exp_b[i]); end
    end
    bus(0, 0, 0, 0);
  endtask

  task automatic test_push_pop();
    for (int i = 0; i < 2; i++) begin
      uart_dout_valid = 1; uart_dout = 8'h21 + 8'(i);
      tick();
    end
    for (int k = 0; k < 6; k++) begin
      uart_dout = 8'h23 + 8'(k);
      bus(1, 0, 32'h8000_0004, 0);
      tick();
      n_vec++; if (dout !== 32'h21 + k || uart_dout_ready !== 1'b1 || m_fifo.size() != 2) begin n_err++;
        $display("FAIL pushpop%0d dout=%h ready=%b exp %h/1", k, dout, uart_dout_ready, 32'h21 + k); end
    end
    uart_dout_valid = 0;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_vec++; if (dout !== 32'h27 + k) begin n_err++; $display("FAIL pushpop_drain%0d dout=%h exp=%h", k, dout, 32'h27 + k); end
    end
    bus(0, 0, 0, 0);
  endtask

  task automatic test_counters();
    bus(0, 4'hF, 32'h8000_0018, 32'hFFFF_FFFF);
    tick();
    bus(0, 0, 0, 0);
    for (int i = 0; i < 100; i++) begin
      inst_retire = i < 40; stall = i < 10;
      tick();
    end
    inst_retire = 0; stall = 0;
    bus(1, 0, 32'h8000_0014, 0);
    tick();
    n_vec++; if (dout !== 32'd30 || dout !== m_dout) begin n_err++; $display("FAIL ins_count dout=%0d exp=30", dout); end
    bus(1, 0, 32'h8000_0010, 0);
    tick();
    n_vec++; if (dout !== 32'd101 || dout !== m_dout) begin n_err++; $display("FAIL cyc_count dout=%0d exp=101", dout); end
    inst_retire = 1;
    bus(0, 4'h2, 32'h8000_0018, 0);
    tick();
    bus(1, 0, 32'h8000_0010, 0);
    tick();
    n_vec++; if (dout !== 32'd0) begin n_err++; $display("FAIL cyc_clear dout=%0d exp=0", dout); end
    bus(1, 0, 32'h8000_0014, 0);
    tick();
    n_vec++; if (dout !== 32'd1 || dout !== m_dout) begin n_err++; $display("FAIL ins_clear dout=%0d exp=1", dout); end
    inst_retire = 0;
    bus(0, 0, 0, 0);
  endtask

  task automatic test_stall_decode();
    logic [31:0] prev;
    uart_dout_valid = 1; uart_dout = 8'h55;
    tick();
    uart_dout_valid = 0;
    prev = dout;
    stall = 1;
    bus(1, 4'hF, 32'h8000_0004, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      n_vec++; if (dout !== prev) begin n_err++; $display("FAIL stall_hold%0d dout=%h exp=%h", i, dout, prev); end
    end
    stall = 0;
    bus(1, 0, 32'h1000_0004, 0);
    tick();
    n_vec++; if (io_sel !== 1'b0 || dout !== prev) begin n_err++;
      $display("FAIL decode_miss io_sel=%b dout=%h exp 0/%h", io_sel, dout, prev); end
    bus(1, 0, 32'h8000_0004, 0);
    tick();
    n_vec++; if (dout !== 32'h55 || io_sel !== 1'b1) begin n_err++; $display("FAIL stall_no_pop dout=%h io_sel=%b exp 00000055/1", dout, io_sel); end
    bus(0, 0, 0, 0);
  endtask

  task automatic test_random();
    logic [7:0] offs [7] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18};
    for (int i = 0; i < 400; i++) begin
      bus($urandom_range(0, 1) == 1, ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0,
          {($urandom_range(0, 4) == 0) ? 4'h1 : 4'h8, 20'h0, offs[$urandom_range(0, 6)]}, $urandom);
      stall = $urandom_range(0, 4) == 0;
      inst_retire = $urandom_range(0, 1) == 1;
      uart_din_ready = $urandom_range(0, 1) == 1;
      uart_dout_valid = $urandom_range(0, 1) == 1;
      uart_dout = 8'($urandom);
      tick();
      n_vec++; if (dout !== m_dout || io_sel !== m_iosel) begin n_err++;
        $display("FAIL rand%0d_read dout=%h io_sel=%b exp %h/%b", i, dout, io_sel, m_dout, m_iosel); end
      n_vec++; if (uart_din_valid !== m_txv || (m_txv && uart_din !== m_txb)) begin n_err++;
        $display("FAIL rand%0d_tx valid=%b din=%h exp %b/%h", i, uart_din_valid, uart_din, m_txv, m_txb); end
      n_vec++; if (uart_dout_ready !== (m_fifo.size() < DEPTH)) begin n_err++;
        $display("FAIL rand%0d_rx_ready got=%b exp=%b", i, uart_dout_ready, m_fifo.size() < DEPTH); end
    end
    bus(0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_tx();
    test_rx_fill();
    test_push_pop();
    test_counters();
    test_stall_decode();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
